// File: rtl/control_unit_if.sv
// Program-memory and ALU bus between the sequencer (master) and its
// combinational memory/ALU (slave).
interface control_unit_if;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [2:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_y;
   logic       alu_zf;

   modport master (
      output mem_addr, alu_op, alu_a, alu_b,
      input  mem_rdata, alu_y, alu_zf
   );

   modport slave (
      input  mem_addr, alu_op, alu_a, alu_b,
      output mem_rdata, alu_y, alu_zf
   );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: 4x8 register file,
// zero flag, immediates and branches fetched from program memory.
module control_unit #(
   parameter logic [7:0] PC_RESET = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   control_unit_if.master        bus,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   output logic                  halted
);
   localparam int NREGS = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_LDI = 3'b011;
   localparam logic [2:0] OP_JZ  = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_OUT = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_IMM, S_HALT
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_pc;
   logic [7:1]  r_ir;
   logic [7:0]  r_regs [NREGS];
   logic        r_z;
   logic [7:0]  r_out_data;
   logic        r_out_valid;

   logic [2:0]  w_op;
   logic [1:0]  w_rd;
   logic [1:0]  w_rs;
   logic        w_is_alu;
   logic [7:0]  w_pc_inc;

   assign w_op     = r_ir[7:5];
   assign w_rd     = r_ir[4:3];
   assign w_rs     = r_ir[2:1];
   assign w_pc_inc = r_pc + 8'd1;
   assign w_is_alu = (r_state == S_EXEC) &&
                     (w_op == OP_ADD || w_op == OP_AND ||
                      w_op == OP_NOT);

   assign bus.mem_addr = r_pc;
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign halted       = (r_state == S_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      bus.alu_op = 3'b000;
      bus.alu_a  = 8'h00;
      bus.alu_b  = 8'h00;
      if (w_is_alu) begin
         bus.alu_op = w_op;
         bus.alu_a  = r_regs[w_rd];
         bus.alu_b  = r_regs[w_rs];
      end
      unique case (r_state)
         S_IDLE:  if (run) w_next = S_FETCH;
         S_FETCH: w_next = S_EXEC;
         S_EXEC: begin
            unique case (w_op)
               OP_LDI, OP_JZ, OP_JMP: w_next = S_IMM;
               OP_HLT:                w_next = S_HALT;
               default:               w_next = S_FETCH;
            endcase
         end
         S_IMM:   w_next = S_FETCH;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath writes are keyed on the current state, so an async reset
   // in any state discards the pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= PC_RESET;
         r_ir        <= '0;
         r_z         <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
      end else begin
         r_out_valid <= 1'b0;
         unique case (r_state)
            S_FETCH: begin
               r_ir <= bus.mem_rdata[7:1];
               r_pc <= w_pc_inc;
            end
            S_EXEC: begin
               if (w_is_alu) begin
                  r_regs[w_rd] <= bus.alu_y;
                  r_z          <= bus.alu_zf;
               end
               if (w_op == OP_OUT) begin
                  r_out_data  <= r_regs[w_rd];
                  r_out_valid <= 1'b1;
               end
            end
            S_IMM: begin
               unique case (w_op)
                  OP_LDI: begin
                     r_regs[w_rd] <= bus.mem_rdata;
                     r_pc         <= w_pc_inc;
                  end
                  OP_JZ:   r_pc <= r_z ? bus.mem_rdata : w_pc_inc;
                  OP_JMP:  r_pc <= bus.mem_rdata;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// Directed program vectors for control_unit with a behavioural
// program memory and ALU on the slave side of the bus.
module tb_control_unit;
   logic       clk;
   logic       rst_n;
   logic       run;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halted;
   logic [7:0] mem [256];

   int n_vec;
   int n_bad;

   control_unit_if bus ();

   control_unit #(.PC_RESET(8'h00)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .bus       (bus),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted)
   );

   assign bus.mem_rdata = mem[bus.mem_addr];

   always_comb begin
      case (bus.alu_op)
         3'b000:  bus.alu_y = bus.alu_a + bus.alu_b;
         3'b001:  bus.alu_y = bus.alu_a & bus.alu_b;
         3'b010:  bus.alu_y = ~bus.alu_a;
         default: bus.alu_y = 8'h00;
      endcase
      bus.alu_zf = (bus.alu_y == 8'h00);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] prog;
      int           cycles;
      logic [7:0]   exp_addr;
      logic [7:0]   exp_out;
      int           exp_nout;
      logic         exp_halt;
      int           exp_alu_n;
      logic [18:0]  exp_alu;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_reset(input logic [127:0] p);
      rst_n = 1'b0;
      run   = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 16; i++) mem[i] = p[127-8*i -: 8];
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic start();
      run = 1'b1;
      @(posedge clk);
      #1;
      run = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int          nout;
      int          nalu;
      logic [18:0] last_alu;
      nout     = 0;
      nalu     = 0;
      last_alu = '0;
      load_reset(v.prog);
      start();
      repeat (v.cycles) begin
         @(posedge clk);
         #1;
         if (out_valid) nout++;
         if ({bus.alu_op, bus.alu_a, bus.alu_b} != 19'd0) begin
            nalu++;
            last_alu = {bus.alu_op, bus.alu_a, bus.alu_b};
         end
      end
      chk({v.name, ".pc"},     {24'd0, bus.mem_addr}, {24'd0, v.exp_addr});
      chk({v.name, ".out"},    {24'd0, out_data},     {24'd0, v.exp_out});
      chk({v.name, ".nout"},   nout,                  v.exp_nout);
      chk({v.name, ".halted"}, {31'd0, halted},       {31'd0, v.exp_halt});
      chk({v.name, ".alu_n"},  nalu,                  v.exp_alu_n);
      chk({v.name, ".alu"},    {13'd0, last_alu},     {13'd0, v.exp_alu});
   endtask

   initial begin
      int nout;
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      run   = 1'b0;

      vecs[0] = '{"t1_jz11", 128'h60FF6801_02802000_00000000_00000000,
                  11, 8'h20, 8'h00, 0, 1'b0, 1, {3'b000, 8'hFF, 8'h01}};
      vecs[1] = '{"t1_r0z", 128'h60FF6801_028008E0_C0E00000_00000000,
                  30, 8'h0A, 8'h00, 1, 1'b1, 1, {3'b000, 8'hFF, 8'h01}};
      vecs[2] = '{"t2_and", 128'h70AA7855_36D0800C_E0000000_E0000000,
                  30, 8'h0D, 8'h00, 1, 1'b1, 1, {3'b001, 8'hAA, 8'h55}};
      vecs[3] = '{"t3_not", 128'h68CC48C8_800CE000_00000000_E0000000,
                  30, 8'h07, 8'h33, 1, 1'b1, 1, {3'b010, 8'hCC, 8'h00}};
      vecs[4] = '{"add", 128'h60126834_08C8E000_00000000_00000000,
                  30, 8'h07, 8'h46, 1, 1'b1, 1, {3'b000, 8'h34, 8'h12}};
      vecs[5] = '{"jmp", 128'h605AA007_C0E0E0C0_E0000000_00000000,
                  30, 8'h09, 8'h5A, 1, 1'b1, 0, 19'd0};
      vecs[6] = '{"ldi_z", 128'h60006800_02700780_0CE00000_D0E00000,
                  30, 8'h0E, 8'h07, 1, 1'b1, 0, 19'd0};

      load_reset(128'h0);
      chk("rst.pc",     {24'd0, bus.mem_addr}, 32'h00);
      chk("rst.out",    {24'd0, out_data},     32'h00);
      chk("rst.valid",  {31'd0, out_valid},    32'h0);
      chk("rst.halted", {31'd0, halted},       32'h0);
      chk("rst.alu",    {13'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'h0);
      step(5);
      chk("idle.pc",    {24'd0, bus.mem_addr}, 32'h00);

      for (int k = 0; k < 7; k++) run_vec(vecs[k]);

      // still halted after the last vector: run toggling must not wake it
      for (int i = 0; i < 20; i++) begin
         run = i[0];
         step(1);
         chk("halt.hold", {31'd0, halted}, 32'h1);
      end
      run = 1'b0;
      chk("halt.pc", {24'd0, bus.mem_addr}, 32'h0E);

      load_reset(128'hA0FF0000_00000000_00000000_00000000);
      mem[255] = 8'h60;
      start();
      step(3);
      chk("wrap.jmp", {24'd0, bus.mem_addr}, 32'hFF);
      step(1);
      chk("wrap.fetch", {24'd0, bus.mem_addr}, 32'h00);
      step(2);
      chk("wrap.imm", {24'd0, bus.mem_addr}, 32'h01);
      step(2);
      chk("wrap.hlt", {31'd0, halted}, 32'h1);
      chk("wrap.pc",  {24'd0, bus.mem_addr}, 32'h02);

      load_reset(128'h6077C0E0_00000000_00000000_00000000);
      start();
      step(2);
      chk("abort.pre", {24'd0, bus.mem_addr}, 32'h01);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort.pc",     {24'd0, bus.mem_addr}, 32'h00);
      chk("abort.out",    {24'd0, out_data},     32'h00);
      chk("abort.valid",  {31'd0, out_valid},    32'h0);
      chk("abort.halted", {31'd0, halted},       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(5);
      chk("abort.idle", {24'd0, bus.mem_addr}, 32'h00);
      mem[0] = 8'hC0;
      mem[1] = 8'hE0;
      start();
      nout = 0;
      repeat (10) begin
         step(1);
         if (out_valid) nout++;
      end
      chk("abort.r0",   {24'd0, out_data}, 32'h00);
      chk("abort.nout", nout,              32'd1);
      chk("abort.hlt",  {31'd0, halted},   32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
